// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Assembles two-byte commands (command code, then address) from a UART
//   receive stream, validates them and hands them to a consumer over a
//   valid/ready handshake. Bad commands, bad addresses, inter-byte timeouts
//   and bytes arriving while a command is in flight are reported as errors.
//
// Ports
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   rx_valid   one-cycle byte-received strobe from the UART receiver
//   rx_byte    received byte, valid with rx_valid
//   cmd_valid  assembled command available
//   cmd_ready  consumer accepts the command
//   cmd_code   command byte (first of pair)
//   cmd_addr   address byte (second of pair)
//   err_pulse  one-cycle error strobe
//   err_code   last error: 0 none, 1 bad command, 2 bad address, 3 overrun/timeout
//   err_count  saturating count of errors
//   busy       high whenever the sequencer is not idle
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a command byte
// S_WAIT_ADDR | command latched, waiting for address byte, timer running
// S_CHECK   | one cycle validating command and address
// S_ISSUE   | cmd_valid high until the consumer takes it

module uart_cmd_sequencer #(
    parameter int TIMEOUT_CLOCKS = 104180,
    parameter int MAX_CMD        = 7,
    parameter int NUM_ADDR       = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_addr,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] err_count,
    output logic       busy
);

    // Just wide enough to hold TIMEOUT_CLOCKS-1.
    localparam int TW = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLOCKS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
        S_CHECK     = 2'd2,
        S_ISSUE     = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic          latch_cmd;
    logic          latch_addr;
    logic          timer_clr;
    logic          timer_inc;
    logic          err_fire;
    logic [1:0]    err_val;
    logic          cmd_bad;
    logic          addr_bad;

    // Compare at 32 bits so parameters beyond the byte range behave sensibly.
    assign cmd_bad  = 32'(cmd_code) > 32'(MAX_CMD);
    assign addr_bad = 32'(cmd_addr) >= 32'(NUM_ADDR);

    assign cmd_valid = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        latch_cmd  = 1'b0;
        latch_addr = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        err_fire   = 1'b0;
        err_val    = 2'd0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    latch_cmd = 1'b1;
                    timer_clr = 1'b1;
                    state_nx  = S_WAIT_ADDR;
                end
            end
            S_WAIT_ADDR: begin
                timer_inc = 1'b1;
                // A byte arriving on the timeout cycle still counts as the address.
                if (rx_valid) begin
                    latch_addr = 1'b1;
                    state_nx   = S_CHECK;
                end else if (timer == TIMER_LAST) begin
                    err_fire = 1'b1;
                    err_val  = 2'd3;
                    state_nx = S_IDLE;
                end
            end
            S_CHECK: begin
                if (cmd_bad) begin
                    err_fire = 1'b1;
                    err_val  = 2'd1;
                    state_nx = S_IDLE;
                end else if (addr_bad) begin
                    err_fire = 1'b1;
                    err_val  = 2'd2;
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_ISSUE;
                    if (rx_valid) begin
                        err_fire = 1'b1;
                        err_val  = 2'd3;
                    end
                end
            end
            S_ISSUE: begin
                if (rx_valid) begin
                    err_fire = 1'b1;
                    err_val  = 2'd3;
                end
                if (cmd_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer_inc && (timer != TIMER_LAST)) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_code <= 8'd0;
            cmd_addr <= 8'd0;
        end else begin
            if (latch_cmd) begin
                cmd_code <= rx_byte;
            end
            if (latch_addr) begin
                cmd_addr <= rx_byte;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= err_fire;
            if (err_fire) begin
                err_code <= err_val;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: directed byte sequences, expected
// commands and errors queued by the stimulus, checked by a negedge monitor.

module tb_uart_cmd_sequencer;

    localparam int TO = 40;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_addr;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic       busy;

    uart_cmd_sequencer #(
        .TIMEOUT_CLOCKS(TO),
        .MAX_CMD(7),
        .NUM_ADDR(32)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_code(cmd_code),
        .cmd_addr(cmd_addr),
        .err_pulse(err_pulse),
        .err_code(err_code),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] addr;
    } cmd_t;

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] cnt;
    } err_t;

    cmd_t exp_cmd[$];
    err_t exp_err[$];
    cmd_t mon_cmd;
    err_t mon_err;
    int   exp_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic push_err(input logic [1:0] code);
        if (exp_cnt < 255) exp_cnt++;
        exp_err.push_back({code, 8'(exp_cnt)});
    endtask

    task automatic push_cmd(input logic [7:0] code, input logic [7:0] addr);
        exp_cmd.push_back({code, addr});
    endtask

    // Called 1 ns after a rising edge; the byte is sampled on the next edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_code"}, 32'(cmd_code), 32'd0);
        check({tag, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
        check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (reset_n) begin
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    n_total++;
                    $display("FAIL cmd_unexpected: got code %0h addr %0h, required none (t=%0t)",
                             cmd_code, cmd_addr, $time);
                end else begin
                    mon_cmd = exp_cmd.pop_front();
                    check("cmd_code", 32'(cmd_code), 32'(mon_cmd.code));
                    check("cmd_addr", 32'(cmd_addr), 32'(mon_cmd.addr));
                end
            end
            if (err_pulse) begin
                if (exp_err.size() == 0) begin
                    n_total++;
                    $display("FAIL err_unexpected: got err_code %0d, required no error (t=%0t)",
                             err_code, $time);
                end else begin
                    mon_err = exp_err.pop_front();
                    check("err_code", 32'(err_code), 32'(mon_err.code));
                    check("err_count", 32'(err_count), 32'(mon_err.cnt));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i;
        logic hold_ok;

        // Reset state
        idle(3);
        check_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic pair with exact latency
        cmd_ready = 1'b1;
        push_cmd(8'h03, 8'h05);
        send_byte(8'h03);
        check("wait_addr_busy", 32'(busy), 32'd1);
        send_byte(8'h05);
        check("check_cycle_no_valid", 32'(cmd_valid), 32'd0);
        idle(1);
        check("issue_valid_n2", 32'(cmd_valid), 32'd1);
        idle(1);
        check("done_valid_n3", 32'(cmd_valid), 32'd0);
        check("done_busy_n3", 32'(busy), 32'd0);
        check("no_err_after_pair", 32'(err_count), 32'd0);

        // Largest legal command and address
        push_cmd(8'h07, 8'h1F);
        send_byte(8'h07);
        send_byte(8'h1F);
        idle(3);

        // Bad command, then bad address
        push_err(2'd1);
        send_byte(8'h09);
        send_byte(8'h01);
        idle(3);
        check("bad_cmd_code", 32'(err_code), 32'd1);
        check("bad_cmd_count", 32'(err_count), 32'd1);
        push_err(2'd2);
        send_byte(8'h02);
        send_byte(8'h20);
        idle(3);
        check("bad_addr_code", 32'(err_code), 32'd2);
        check("bad_addr_count", 32'(err_count), 32'd2);

        // Both bad: command error wins
        push_err(2'd1);
        send_byte(8'h09);
        send_byte(8'h20);
        idle(3);
        check("prio_code", 32'(err_code), 32'd1);

        // Byte in CHECK with a bad command is dropped silently
        push_err(2'd1);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h55);
        idle(3);

        // Byte in CHECK with a good pair is an overrun, command still issues
        push_cmd(8'h03, 8'h04);
        push_err(2'd3);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h55);
        idle(3);
        check("check_overrun_code", 32'(err_code), 32'd3);

        // Timeout exactly TO cycles after command latch
        push_err(2'd3);
        send_byte(8'h01);
        i = 0;
        while (!err_pulse && i < 3 * TO) begin
            idle(1);
            i++;
        end
        check("timeout_cycles", 32'(i), 32'(TO));
        check("timeout_busy_low", 32'(busy), 32'd0);
        idle(1);
        check("timeout_pulse_one_cycle", 32'(err_pulse), 32'd0);

        // Address byte on the timeout cycle is accepted
        push_cmd(8'h01, 8'h03);
        send_byte(8'h01);
        idle(TO - 1);
        send_byte(8'h03);
        idle(3);
        check("edge_accept_count", 32'(err_count), 32'(exp_cnt));

        // Back-pressure with overrun byte during ISSUE
        cmd_ready = 1'b0;
        push_cmd(8'h01, 8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(1);
        check("stall_valid", 32'(cmd_valid), 32'd1);
        push_err(2'd3);
        send_byte(8'h04);
        hold_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!(cmd_valid && cmd_code == 8'h01 && cmd_addr == 8'h02)) hold_ok = 1'b0;
            idle(1);
        end
        check("stall_hold", 32'(hold_ok), 32'd1);
        check("stall_err_code", 32'(err_code), 32'd3);
        cmd_ready = 1'b1;
        idle(1);
        check("stall_release_valid", 32'(cmd_valid), 32'd0);
        check("stall_release_busy", 32'(busy), 32'd0);

        // Saturation
        repeat (300) begin
            push_err(2'd1);
            send_byte(8'hFF);
            send_byte(8'h00);
            idle(1);
        end
        idle(2);
        check("sat_count", 32'(err_count), 32'd255);

        // Reset during WAIT_ADDR
        send_byte(8'h05);
        #2;
        reset_n = 1'b0;
        exp_cnt = 0;
        #1;
        check_zero("rst_wait");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send_byte(8'h06);
        idle(2);
        check("rst_wait_new_cmd_busy", 32'(busy), 32'd1);
        check("rst_wait_no_valid", 32'(cmd_valid), 32'd0);
        push_cmd(8'h06, 8'h07);
        send_byte(8'h07);
        idle(3);

        // Reset during ISSUE
        cmd_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        idle(1);
        check("rst_issue_pre_valid", 32'(cmd_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        exp_cnt = 0;
        #1;
        check_zero("rst_issue");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        cmd_ready = 1'b1;
        idle(4);
        check("rst_issue_no_valid", 32'(cmd_valid), 32'd0);
        push_cmd(8'h02, 8'h03);
        send_byte(8'h02);
        send_byte(8'h03);
        idle(5);

        check("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        check("err_queue_drained", 32'(exp_err.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
